// File: rtl/calc_scheduler.sv
`timescale 1ns/1ps
// calc_scheduler: round-robin front end that serialises four requesters onto one shared calculator.
// Optional stall watchdog is compiled in by defining CALC_SCHED_TIMEOUT_EN.
module calc_scheduler #(
    parameter int CALC_LATENCY = 1,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk_100MHz,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    output logic [3:0]  gnt,
    output logic [3:0]  done,
    output logic [7:0]  result,
    output logic        err,
    output logic        busy,
    output logic [7:0]  o2cData,
    input  logic [7:0]  c2oData,
    input  logic        operation_enable,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] r_winner;
    logic [1:0] r_last;
    logic [1:0] w_pick;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_dec;
    logic [7:0] r_o2c;
    logic [7:0] r_result;
    logic       w_timeout;

    if (CALC_LATENCY < 1 || CALC_LATENCY > 15) begin : g_bad_latency
        $error("calc_scheduler: CALC_LATENCY must be 1..15");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("calc_scheduler: TIMEOUT must be 1..255");
    end

    // Handshake: req[i] is valid and stays high with its operand slice through the cycle gnt[i] is high;
    // gnt[i] is the one-cycle accept, and done[i] is a one-cycle return qualifying result/err.
    always_comb begin : rr_pick
        logic [1:0] v_idx;
        logic       v_found;
        v_idx   = '0;
        v_found = 1'b0;
        w_pick  = r_last;
        for (int k = 1; k <= 4; k++) begin
            v_idx = r_last + 2'(k);
            if (!v_found && req[v_idx]) begin
                w_pick  = v_idx;
                v_found = 1'b1;
            end
        end
    end

    assign w_cnt_dec = r_cnt - 4'd1;

`ifdef CALC_SCHED_TIMEOUT_EN
    logic [7:0] r_wd;
    logic       r_abort;

    assign w_timeout = (r_state == S_WAIT) && !operation_enable && (r_wd == 8'(TIMEOUT - 1));
    assign err       = (r_state == S_DONE) && r_abort;

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            r_wd    <= 8'd0;
            r_abort <= 1'b0;
        end else begin
            case (r_state)
                S_ISSUE: begin
                    r_wd    <= 8'd0;
                    r_abort <= 1'b0;
                end
                S_WAIT: begin
                    if (operation_enable) r_wd    <= 8'd0;
                    else if (w_timeout)   r_abort <= 1'b1;
                    else                  r_wd    <= r_wd + 8'd1;
                end
                default: ;
            endcase
        end
    end
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if ((req != 4'b0) && operation_enable) w_next_state = S_ISSUE;
            S_ISSUE: w_next_state = S_WAIT;
            S_WAIT:  if ((operation_enable && (w_cnt_dec == 4'd0)) || w_timeout) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_winner <= 2'd0;
            r_last   <= 2'd3;
            r_cnt    <= 4'd0;
            r_o2c    <= 8'd0;
            r_result <= 8'd0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE:  if (w_next_state == S_ISSUE) r_winner <= w_pick;
                S_ISSUE: begin
                    r_o2c <= req_data[8*r_winner +: 8];
                    r_cnt <= 4'(CALC_LATENCY);
                end
                S_WAIT: begin
                    if (operation_enable) begin
                        r_cnt <= w_cnt_dec;
                        if (w_cnt_dec == 4'd0) r_result <= c2oData;
                    end else if (w_timeout) begin
                        r_result <= 8'hFF;
                    end
                end
                S_DONE:  r_last <= r_winner;
                default: ;
            endcase
        end
    end

    assign gnt         = (r_state == S_ISSUE) ? (4'b0001 << r_winner) : 4'b0000;
    assign done        = (r_state == S_DONE)  ? (4'b0001 << r_winner) : 4'b0000;
    assign busy        = (r_state != S_IDLE);
    assign result      = r_result;
    assign o2cData     = r_o2c;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_calc_scheduler.sv
`timescale 1ns/1ps
// tb_calc_scheduler: directed scenarios plus a randomized run against a transaction-level
// round-robin model; the shared calculator is modelled as an echo with CALC_LATENCY delay.
module tb_calc_scheduler;
  localparam int LAT = 1;
  localparam int TMO = 8;

  logic        clk_100MHz = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = 4'b0;
  logic [31:0] req_data = 32'b0;
  logic        operation_enable = 1'b1;
  logic [7:0]  c2oData;
  logic [3:0]  gnt, done;
  logic [7:0]  result, o2cData;
  logic        err, busy;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int m_last = 3;
  logic [9:0] exp_q[$];

  calc_scheduler #(.CALC_LATENCY(LAT), .TIMEOUT(TMO)) dut (
    .clk_100MHz(clk_100MHz), .rst(rst), .req(req), .req_data(req_data),
    .gnt(gnt), .done(done), .result(result), .err(err), .busy(busy),
    .o2cData(o2cData), .c2oData(c2oData), .operation_enable(operation_enable),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_100MHz = ~clk_100MHz;
  always @(posedge clk_100MHz) cyc <= cyc + 1;

  // Calculator: echo of the operand, available LAT edges after it is driven.
  logic [7:0] hist [0:15];
  always @(posedge clk_100MHz) begin
    hist[0] <= o2cData;
    for (int i = 1; i < 16; i++) hist[i] <= hist[i-1];
  end
  assign c2oData = (LAT == 1) ? o2cData : hist[(LAT >= 2) ? LAT - 2 : 0];

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation ran past 500us");
    $fatal(1, "global timeout");
  end

  // ---------------- model ----------------
  function automatic int rr_pick(input logic [3:0] pend, input int last);
    for (int k = 1; k <= 4; k++)
      if (pend[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst = 1'b1; req = 4'b0; req_data = 32'b0; operation_enable = 1'b1;
    repeat (2) @(negedge clk_100MHz);
    rst = 1'b0;
    m_last = 3;
  endtask

  task automatic wait_gnt(input int budget, output logic [3:0] g, output int c, output bit to);
    to = 1'b1; g = 4'b0; c = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_100MHz);
      if (gnt !== 4'b0) begin g = gnt; c = cyc; to = 1'b0; break; end
    end
  endtask

  task automatic wait_done(input int budget, output logic [3:0] d, output logic [7:0] r,
                           output logic e, output int c, output bit to);
    to = 1'b1; d = 4'b0; r = 8'b0; e = 1'b0; c = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_100MHz);
      if (done !== 4'b0) begin d = done; r = result; e = err; c = cyc; to = 1'b0; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk_100MHz);
    checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    checks++; if (done !== 4'b0) begin errors++; $display("FAIL reset_done: got %b want 0000", done); end
    checks++; if (result !== 8'h00) begin errors++; $display("FAIL reset_result: got %h want 00", result); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (o2cData !== 8'h00) begin errors++; $display("FAIL reset_o2c: got %h want 00", o2cData); end
    rst = 1'b0;
    m_last = 3;
  endtask

  task automatic test_single();
    logic [3:0] g, d; logic [7:0] r; logic e; int gc, dc; bit to;
    req = 4'b0001; req_data = 32'h0000_002A; operation_enable = 1'b1;
    wait_gnt(10, g, gc, to);
    checks++; if (to || g !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b timeout=%0d want 0001", g, to); end
    req = 4'b0;
    wait_done(10, d, r, e, dc, to);
    checks++; if (to || d !== 4'b0001) begin errors++; $display("FAIL single_done: got %b timeout=%0d want 0001", d, to); end
    checks++; if (dc - gc != LAT + 1) begin errors++; $display("FAIL single_latency: got %0d want %0d", dc - gc, LAT + 1); end
    checks++; if (r !== 8'h2A) begin errors++; $display("FAIL single_result: got %h want 2a", r); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL single_err: got %b want 0", e); end
    checks++; if (o2cData !== 8'h2A) begin errors++; $display("FAIL single_o2c_hold: got %h want 2a", o2cData); end
    m_last = 0;
  endtask

  task automatic test_round_robin();
    logic [3:0] d; logic [7:0] r; logic e; int dc, prev_dc, exp_w; bit to;
    logic [31:0] ops;
    apply_reset();
    ops = 32'h4030_2010;
    req = 4'b1111; req_data = ops; operation_enable = 1'b1;
    prev_dc = 0;
    for (int n = 0; n < 5; n++) begin
      exp_w = rr_pick(4'b1111, m_last);
      wait_done(20, d, r, e, dc, to);
      checks++; if (to || d !== 4'(1 << exp_w)) begin errors++; $display("FAIL rr_order[%0d]: got %b want %b", n, d, 4'(1 << exp_w)); end
      checks++; if (r !== ops[8*exp_w +: 8] || e !== 1'b0) begin errors++; $display("FAIL rr_result[%0d]: got %h err=%b want %h", n, r, e, ops[8*exp_w +: 8]); end
      if (n > 0) begin
        checks++; if (dc - prev_dc != LAT + 3) begin errors++; $display("FAIL rr_spacing[%0d]: got %0d want %0d", n, dc - prev_dc, LAT + 3); end
      end
      prev_dc = dc;
      m_last = exp_w;
    end
    req = 4'b0;
    repeat (3) @(negedge clk_100MHz);
  endtask

  task automatic test_stall();
    logic [3:0] g, d; logic [7:0] r, op; logic e; int gc, dc; bit to, quiet;
    op = 8'($urandom_range(255, 1));
    req = 4'b0100; req_data = {8'h00, op, 16'h0000}; operation_enable = 1'b1;
    wait_gnt(10, g, gc, to);
    checks++; if (to || g !== 4'b0100) begin errors++; $display("FAIL stall_gnt: got %b want 0100", g); end
    req = 4'b0; operation_enable = 1'b0;
    quiet = 1'b1;
    repeat (6) begin
      @(negedge clk_100MHz);
      if (done !== 4'b0) quiet = 1'b0;
    end
    checks++; if (!quiet) begin errors++; $display("FAIL stall_early_done: got done during stall want none"); end
    operation_enable = 1'b1;
    wait_done(10, d, r, e, dc, to);
    checks++; if (to || d !== 4'b0100) begin errors++; $display("FAIL stall_done: got %b want 0100", d); end
    checks++; if (dc - gc != LAT + 1 + 5) begin errors++; $display("FAIL stall_latency: got %0d want %0d", dc - gc, LAT + 6); end
    checks++; if (r !== op || e !== 1'b0) begin errors++; $display("FAIL stall_result: got %h err=%b want %h", r, e, op); end
    m_last = 2;
  endtask

  task automatic test_reset_in_wait();
    logic [3:0] g, d; logic [7:0] r, op; logic e; int gc, dc; bit to, quiet;
    op = 8'($urandom_range(255, 1));
    req = 4'b1000; req_data = {op, 24'h0}; operation_enable = 1'b1;
    wait_gnt(10, g, gc, to);
    checks++; if (to || g !== 4'b1000) begin errors++; $display("FAIL rstw_gnt: got %b want 1000", g); end
    req = 4'b0; operation_enable = 1'b0;
    repeat (2) @(negedge clk_100MHz);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstw_busy_before: got %b want 1", busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || gnt !== 4'b0 || done !== 4'b0 || err !== 1'b0) begin
      errors++; $display("FAIL rstw_async_ctrl: got busy=%b gnt=%b done=%b err=%b want all 0", busy, gnt, done, err); end
    checks++; if (result !== 8'h00 || o2cData !== 8'h00) begin
      errors++; $display("FAIL rstw_async_data: got result=%h o2c=%h want 00/00", result, o2cData); end
    @(negedge clk_100MHz);
    rst = 1'b0; operation_enable = 1'b1; m_last = 3;
    quiet = 1'b1;
    repeat (6) begin
      @(negedge clk_100MHz);
      if (done !== 4'b0 || gnt !== 4'b0) quiet = 1'b0;
    end
    checks++; if (!quiet) begin errors++; $display("FAIL rstw_discard: got activity after reset want none"); end
    op = 8'($urandom_range(255, 1));
    req = 4'b0010; req_data = {16'h0, op, 8'h0};
    wait_gnt(10, g, gc, to);
    checks++; if (to || g !== 4'b0010) begin errors++; $display("FAIL rstw_resume_gnt: got %b want 0010", g); end
    req = 4'b0;
    wait_done(10, d, r, e, dc, to);
    checks++; if (to || d !== 4'b0010 || r !== op || dc - gc != LAT + 1) begin
      errors++; $display("FAIL rstw_resume_done: got %b res=%h lat=%0d want 0010 res=%h lat=%0d", d, r, dc - gc, op, LAT + 1); end
    m_last = 1;
  endtask

  task automatic test_withdraw();
    logic [3:0] g; logic [7:0] op; int gc; bit to, saw0, bad1, res_ok;
    op = 8'($urandom_range(255, 1));
    req = 4'b0001; req_data = {24'h0, op}; operation_enable = 1'b1;
    wait_gnt(10, g, gc, to);
    checks++; if (to || g !== 4'b0001) begin errors++; $display("FAIL wd_gnt: got %b want 0001", g); end
    req = 4'b0;
    saw0 = 1'b0; bad1 = 1'b0; res_ok = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk_100MHz);
      if (done[0] === 1'b1) begin saw0 = 1'b1; res_ok = (result === op); end
      if (gnt[1] !== 1'b0 || done[1] !== 1'b0) bad1 = 1'b1;
      if (i == 1) req = 4'b0010;
      else req = 4'b0;
    end
    checks++; if (!saw0 || !res_ok) begin errors++; $display("FAIL wd_req0_done: got seen=%0d ok=%0d want 1/1", saw0, res_ok); end
    checks++; if (bad1) begin errors++; $display("FAIL wd_withdrawn: got gnt/done for requester 1 want none"); end
    m_last = 0;
  endtask

`ifdef CALC_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    logic [3:0] g, d; logic [7:0] r; logic e; int gc, dc; bit to;
    req = 4'b0100; req_data = {8'h0, 8'($urandom_range(255, 1)), 16'h0}; operation_enable = 1'b1;
    wait_gnt(10, g, gc, to);
    checks++; if (to || g !== 4'b0100) begin errors++; $display("FAIL tmo_gnt: got %b want 0100", g); end
    req = 4'b0; operation_enable = 1'b0;
    wait_done(30, d, r, e, dc, to);
    checks++; if (to || d !== 4'b0100 || dc - gc != TMO + 1) begin
      errors++; $display("FAIL tmo_done: got %b lat=%0d want 0100 lat=%0d", d, dc - gc, TMO + 1); end
    checks++; if (r !== 8'hFF || e !== 1'b1) begin errors++; $display("FAIL tmo_result: got %h err=%b want ff/1", r, e); end
    @(negedge clk_100MHz);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_idle: got busy=%b want 0", busy); end
    operation_enable = 1'b1;
    m_last = 2;
  endtask
`endif

  task automatic test_random();
    logic [3:0] drv_req, prev_req, granted; logic [31:0] drv_data, prev_data;
    logic [9:0] item; int exp_w, zeros, served;
    drv_req = 4'b0; prev_req = 4'b0; drv_data = 32'b0; prev_data = 32'b0;
    zeros = 0; served = 0;
    exp_q.delete();
    for (int n = 0; n < 600; n++) begin
      @(negedge clk_100MHz);
      granted = 4'b0;
      if (gnt !== 4'b0) begin
        exp_w = rr_pick(prev_req, m_last);
        checks++;
        if (exp_w < 0 || gnt !== 4'(1 << exp_w) || exp_q.size() != 0) begin
          errors++; $display("FAIL rand_gnt: got %b want %b outstanding=%0d", gnt, (exp_w < 0) ? 4'b0 : 4'(1 << exp_w), exp_q.size());
        end
        if (exp_w >= 0) begin
          exp_q.push_back({2'(exp_w), prev_data[8*exp_w +: 8]});
          granted[exp_w] = 1'b1;
        end
        granted = granted | gnt;
      end
      if (done !== 4'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_done_unexpected: got %b want none", done);
        end else begin
          item = exp_q.pop_front();
          if (done !== 4'(1 << item[9:8]) || result !== item[7:0] || err !== 1'b0) begin
            errors++; $display("FAIL rand_done: got %b res=%h err=%b want %b res=%h err=0", done, result, err, 4'(1 << item[9:8]), item[7:0]);
          end
          m_last = int'(item[9:8]);
          served++;
        end
      end
      drv_req = drv_req & ~granted;
      for (int i = 0; i < 4; i++) begin
        if (n < 500 && !drv_req[i] && !granted[i] && $urandom_range(3, 0) == 0) begin
          drv_req[i] = 1'b1;
          drv_data[8*i +: 8] = 8'($urandom);
        end
      end
      if (zeros >= 3) operation_enable = 1'b1;
      else operation_enable = ($urandom_range(3, 0) != 0);
      zeros = operation_enable ? 0 : zeros + 1;
      req = drv_req; req_data = drv_data;
      prev_req = drv_req; prev_data = drv_data;
    end
    checks++; if (exp_q.size() != 0 || drv_req != 4'b0) begin
      errors++; $display("FAIL rand_drain: got outstanding=%0d pending=%b want 0/0000", exp_q.size(), drv_req); end
    checks++; if (served < 30) begin errors++; $display("FAIL rand_throughput: got %0d served want at least 30", served); end
    operation_enable = 1'b1;
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_reset_in_wait();
    test_withdraw();
`ifdef CALC_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
